game_input_ctrl: RTL

Front-end input controller for the 20×15 space shooter engine. Converts raw, bouncy player button levels into the single-cycle `left`/`right`/`shoot` pulses that `game_design` consumes, with auto-repeat for movement and a fire cooldown. Also generates periodic pseudo-random `enemy_spawn` requests with `enemy_init_x`/`enemy_init_y` when the engine runs with `AUTO_SPAWN(0)`. Its outputs connect port-for-port to the engine's input side.

---
 rtl/game_pkg.sv | 31 +++
 rtl/btn_debounce.sv | 54 +++++
 rtl/game_input_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants and helpers for the space shooter input front end.
// Covers the grid geometry, the spawn LFSR and the spawn column wrap.
package game_pkg;

    localparam int GRID_W = 20;
    localparam int GRID_H = 15;
    localparam int X_W    = 5;
    localparam int Y_W    = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Feedback taps at bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic level;
        logic press;
    } btn_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

    function automatic logic [X_W-1:0] wrap_x(input logic [X_W-1:0] v);
        if (v < X_W'(GRID_W)) begin
            return v;
        end else begin
            return v - X_W'(GRID_W);
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, mismatch-count debouncer and a registered
// rising-edge press strobe that lines up with the debounced level.
module btn_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // The accepted state flips on the DEBOUNCE_CYCLES-th consecutive mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_state) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_state <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
            r_level <= r_state;
            r_press <= r_state & ~r_level;
        end
    end

    assign level = r_level;
    assign press = r_press;

endmodule

// File: rtl/game_input_ctrl.sv
// Player input front end: movement pulses with auto-repeat and left/right
// cancel, fire with cooldown, and a periodic pseudo-random enemy spawner.
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4,
    parameter int FIRE_COOLDOWN   = 8,
    parameter int SPAWN_PERIOD    = 64,
    parameter int SPAWN_Y         = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           btn_left,
    input  logic           btn_right,
    input  logic           btn_fire,
    input  logic           spawn_en,
    output logic           left,
    output logic           right,
    output logic           shoot,
    output logic           enemy_spawn,
    output logic [X_W-1:0] enemy_init_x,
    output logic [Y_W-1:0] enemy_init_y
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam int CD_W    = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN) : 1;
    localparam int SP_W    = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

    btn_t w_left;
    btn_t w_right;
    btn_t w_fire;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk(clk), .rst(rst), .raw(btn_left), .level(w_left.level), .press(w_left.press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk(clk), .rst(rst), .raw(btn_right), .level(w_right.level), .press(w_right.press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fire (
        .clk(clk), .rst(rst), .raw(btn_fire), .level(w_fire.level), .press(w_fire.press)
    );

    logic             r_left;
    logic             r_right;
    logic             r_both;
    logic             r_rate_l;
    logic             r_rate_r;
    logic [REP_W-1:0] r_rep_l;
    logic [REP_W-1:0] r_rep_r;
    logic             r_shoot;
    logic [CD_W-1:0]  r_cool;
    logic [7:0]       r_lfsr;
    logic [SP_W-1:0]  r_timer;
    logic             r_spawn;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;

    logic w_ok_l;
    logic w_ok_r;
    logic w_fresh_l;
    logic w_fresh_r;
    logic w_hit_l;
    logic w_hit_r;

    // Leaving the both-held state counts as a new press for the survivor.
    assign w_ok_l    = w_left.level & ~w_right.level;
    assign w_ok_r    = w_right.level & ~w_left.level;
    assign w_fresh_l = w_left.press | r_both;
    assign w_fresh_r = w_right.press | r_both;
    assign w_hit_l   = r_rate_l ? (r_rep_l == REP_W'(REPEAT_RATE - 1))
                                : (r_rep_l == REP_W'(REPEAT_DELAY - 1));
    assign w_hit_r   = r_rate_r ? (r_rep_r == REP_W'(REPEAT_RATE - 1))
                                : (r_rep_r == REP_W'(REPEAT_DELAY - 1));

    // Movement pulses: first pulse on press, then REPEAT_DELAY, then every REPEAT_RATE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_left   <= 1'b0;
            r_right  <= 1'b0;
            r_both   <= 1'b0;
            r_rate_l <= 1'b0;
            r_rate_r <= 1'b0;
            r_rep_l  <= '0;
            r_rep_r  <= '0;
        end else begin
            r_both <= w_left.level & w_right.level;

            if (!w_ok_l) begin
                r_left   <= 1'b0;
                r_rep_l  <= '0;
                r_rate_l <= 1'b0;
            end else if (w_fresh_l || w_hit_l) begin
                r_left   <= 1'b1;
                r_rep_l  <= '0;
                r_rate_l <= ~w_fresh_l;
            end else begin
                r_left  <= 1'b0;
                r_rep_l <= r_rep_l + REP_W'(1);
            end

            if (!w_ok_r) begin
                r_right  <= 1'b0;
                r_rep_r  <= '0;
                r_rate_r <= 1'b0;
            end else if (w_fresh_r || w_hit_r) begin
                r_right  <= 1'b1;
                r_rep_r  <= '0;
                r_rate_r <= ~w_fresh_r;
            end else begin
                r_right <= 1'b0;
                r_rep_r <= r_rep_r + REP_W'(1);
            end
        end
    end

    // Fire: presses arriving while the cooldown runs are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shoot <= 1'b0;
            r_cool  <= '0;
        end else if (w_fire.press && (r_cool == '0)) begin
            r_shoot <= 1'b1;
            r_cool  <= CD_W'(FIRE_COOLDOWN - 1);
        end else begin
            r_shoot <= 1'b0;
            if (r_cool != '0) begin
                r_cool <= r_cool - CD_W'(1);
            end else begin
                r_cool <= '0;
            end
        end
    end

    // Spawn timer; the column comes from the LFSR value of the terminal-count cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr  <= LFSR_SEED;
            r_timer <= '0;
            r_spawn <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
            if (!spawn_en) begin
                r_timer <= '0;
                r_spawn <= 1'b0;
            end else if (r_timer == SP_W'(SPAWN_PERIOD - 1)) begin
                r_timer <= '0;
                r_spawn <= 1'b1;
                r_x     <= wrap_x(r_lfsr[X_W-1:0]);
                r_y     <= Y_W'(SPAWN_Y);
            end else begin
                r_timer <= r_timer + SP_W'(1);
                r_spawn <= 1'b0;
            end
        end
    end

    assign left         = r_left;
    assign right        = r_right;
    assign shoot        = r_shoot;
    assign enemy_spawn  = r_spawn;
    assign enemy_init_x = r_x;
    assign enemy_init_y = r_y;

endmodule
